// File: rtl/cache_fill_ctrl_if.sv
// Main-memory port of the cache fill controller: read/write requests out,
// returned read words in.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              read_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;

  modport master (
    output read_req, mem_wr_req, memory_address, mem_wdata,
    input  memory_data_valid, memory_data
  );

  modport slave (
    input  read_req, mem_wr_req, memory_address, mem_wdata,
    output memory_data_valid, memory_data
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: counts out one read per block word, writes returned words
// and the tag. Define CACHE_FILL_WB_EN to write back a dirty victim before the fill.
module cache_fill_ctrl #(
  parameter int   ADDR_W = 16,
  parameter int   DATA_W = 16,
  parameter int   WORDS  = 8,
  localparam int  OFF_W  = $clog2(WORDS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrt,
  input  logic                    miss_detected,
  input  logic [ADDR_W-1:0]       miss_address,
  input  logic                    pause,
  input  logic                    victim_dirty,
  input  logic [ADDR_W-OFF_W-1:0] victim_block,
  input  logic [DATA_W-1:0]       cache_rdata,
  output logic                    fsm_busy,
  output logic                    wrt_mem,
  output logic                    write_data_array,
  output logic                    write_tag_array,
  output logic [ADDR_W-1:0]       cache_address,
  cache_fill_ctrl_if.master       mem
);

  localparam logic [OFF_W-1:0] CNT_WORDS = OFF_W'(WORDS);
  localparam logic [OFF_W-1:0] CNT_LAST  = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1
`ifdef CACHE_FILL_WB_EN
    , WB = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d, state_cur;
  logic [OFF_W-1:0] req_cnt_q, req_cnt_d;
  logic [OFF_W-1:0] ret_cnt_q, ret_cnt_d;

  // A reset in progress is presented as IDLE so an interrupted fill can never
  // finish with a tag write or a late data-array write.
  assign state_cur = rst ? state_q : IDLE;

`ifdef CACHE_FILL_WB_EN
  assign mem.mem_wdata = cache_rdata;
`else
  assign mem.mem_wdata = '0;
  logic unused_wb_inputs;
  assign unused_wb_inputs = ^{victim_dirty, victim_block, cache_rdata};
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d             = state_q;
    req_cnt_d           = req_cnt_q;
    ret_cnt_d           = ret_cnt_q;
    fsm_busy            = 1'b0;
    wrt_mem             = 1'b0;
    write_data_array    = 1'b0;
    write_tag_array     = 1'b0;
    cache_address       = miss_address;
    mem.memory_address  = miss_address;
    mem.read_req        = 1'b0;
    mem.mem_wr_req      = 1'b0;

    case (state_cur)
      IDLE: begin
        write_data_array = wrt & ~miss_detected;
        wrt_mem          = wrt & ~miss_detected;
        fsm_busy         = miss_detected;
        if (miss_detected) begin
          req_cnt_d = '0;
          ret_cnt_d = '0;
`ifdef CACHE_FILL_WB_EN
          state_d   = victim_dirty ? WB : FILL;
`else
          state_d   = FILL;
`endif
        end
      end

`ifdef CACHE_FILL_WB_EN
      WB: begin
        fsm_busy           = 1'b1;
        cache_address      = {victim_block, req_cnt_q[OFF_W-2:0], 1'b0};
        mem.memory_address = {victim_block, req_cnt_q[OFF_W-2:0], 1'b0};
        if (!pause) begin
          mem.mem_wr_req = 1'b1;
          if (req_cnt_q == CNT_LAST) begin
            req_cnt_d = '0;
            state_d   = FILL;
          end else begin
            req_cnt_d = req_cnt_q + OFF_W'(1);
          end
        end
      end
`endif

      FILL: begin
        fsm_busy           = 1'b1;
        mem.memory_address = {miss_address[ADDR_W-1:OFF_W], req_cnt_q[OFF_W-2:0], 1'b0};
        cache_address      = {miss_address[ADDR_W-1:OFF_W], ret_cnt_q[OFF_W-2:0], 1'b0};
        if ((req_cnt_q < CNT_WORDS) && !pause) begin
          mem.read_req = 1'b1;
          req_cnt_d    = req_cnt_q + OFF_W'(1);
        end
        // Completion is decided by returned words only, so memory latency is free.
        if (mem.memory_data_valid) begin
          write_data_array = 1'b1;
          ret_cnt_d        = ret_cnt_q + OFF_W'(1);
          if (ret_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: directed misses push expected memory and
// array traffic into queues; a negedge monitor pops and compares each event.
module tb_cache_fill_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int OFF_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    wrt = 1'b0;
  logic                    miss_detected = 1'b0;
  logic                    pause = 1'b0;
  logic                    victim_dirty = 1'b0;
  logic [ADDR_W-1:0]       miss_address = 16'h1234;
  logic [ADDR_W-OFF_W-1:0] victim_block = '0;
  logic [DATA_W-1:0]       cache_rdata;
  logic                    fsm_busy, wrt_mem, write_data_array, write_tag_array;
  logic [ADDR_W-1:0]       cache_address;

  cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk              (clk),
    .rst              (rst),
    .wrt              (wrt),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .pause            (pause),
    .victim_dirty     (victim_dirty),
    .victim_block     (victim_block),
    .cache_rdata      (cache_rdata),
    .fsm_busy         (fsm_busy),
    .wrt_mem          (wrt_mem),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_address    (cache_address),
    .mem              (mem.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [DATA_W-1:0] cache_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h0F0F;
  endfunction

  assign cache_rdata = cache_word(cache_address);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              chk;
    logic              wmem;
  } wr_t;

  typedef struct packed {
    int                due;
    logic [ADDR_W-1:0] addr;
  } pend_t;

  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] tag_q[$];
  wr_t               wr_q[$];
  wr_t               wb_q[$];
  pend_t             pend_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_lat = 3;
  int busy_total = 0;
  int wr_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [ADDR_W-1:0] a);
    n_vec++;
    n_err++;
    $display("FAIL %s: event at address 0x%0h, expected none", name, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: a read sampled in cycle c returns its word in cycle c+mem_lat.
  initial begin
    pend_t p;
    mem.memory_data_valid = 1'b0;
    mem.memory_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        mem.memory_data_valid = 1'b1;
        mem.memory_data       = mem_word(p.addr);
      end else begin
        mem.memory_data_valid = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (fsm_busy) busy_total++;
      if (mem.read_req) begin
        pend_q.push_back('{due: cyc + mem_lat, addr: mem.memory_address});
        if (rd_q.size() == 0) unexpected("read_req", mem.memory_address);
        else check("rd_addr", 32'(mem.memory_address), 32'(rd_q.pop_front()));
      end
      if (mem.mem_wr_req) begin
        if (wb_q.size() == 0) unexpected("mem_wr_req", mem.memory_address);
        else begin
          e = wb_q.pop_front();
          check("wb_mem_addr", 32'(mem.memory_address), 32'(e.addr));
          check("wb_cache_addr", 32'(cache_address), 32'(e.addr));
          check("wb_data", 32'(mem.mem_wdata), 32'(e.data));
        end
      end
      if (write_data_array) begin
        wr_total++;
        if (wr_q.size() == 0) unexpected("write_data_array", cache_address);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", 32'(cache_address), 32'(e.addr));
          check("wr_wrt_mem", 32'(wrt_mem), 32'(e.wmem));
          if (e.chk) check("wr_data", 32'(mem.memory_data), 32'(e.data));
        end
      end
      if (write_tag_array) begin
        if (tag_q.size() == 0) unexpected("write_tag_array", cache_address);
        else check("tag_addr", 32'(cache_address), 32'(tag_q.pop_front()));
      end
    end
  end

  task automatic push_fill(input logic [ADDR_W-1:0] a, input int n_rd, input int n_wr, input bit tag);
    logic [ADDR_W-1:0] base;
    base = {a[ADDR_W-1:OFF_W], 4'h0};
    for (int i = 0; i < n_rd; i++) rd_q.push_back(base + 16'(2 * i));
    for (int i = 0; i < n_wr; i++)
      wr_q.push_back('{addr: base + 16'(2 * i), data: mem_word(base + 16'(2 * i)), chk: 1'b1, wmem: 1'b0});
    if (tag) tag_q.push_back(base + 16'hE);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_left"}, 32'(rd_q.size()), 0);
    check({tag, "_wr_left"}, 32'(wr_q.size()), 0);
    check({tag, "_wb_left"}, 32'(wb_q.size()), 0);
    check({tag, "_tag_left"}, 32'(tag_q.size()), 0);
  endtask

  // One full miss; miss_detected is held three cycles to show repeats are ignored.
  task automatic run_miss(input string tag, input logic [ADDR_W-1:0] a, input int p_after,
                          input int p_len, input bit dirty, input int exp_busy);
    int b0;
    push_fill(a, WORDS, WORDS, 1'b1);
    if (dirty)
      for (int i = 0; i < WORDS; i++)
        wb_q.push_back('{addr: {8'h0, 8'hAB} << 4 | 16'(2 * i),
                         data: cache_word(({8'h0, 8'hAB} << 4) | 16'(2 * i)), chk: 1'b1, wmem: 1'b0});
    b0            = busy_total;
    miss_address  = a;
    miss_detected = 1'b1;
    victim_dirty  = dirty;
    victim_block  = 12'h0AB;
    for (int k = 1; k <= 30; k++) begin
      tick();
      miss_detected = (k < 3);
      pause         = (k > p_after) && (k <= p_after + p_len);
    end
    victim_dirty = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'(exp_busy));
    check_drained(tag);
  endtask

  initial begin
    int w0;
    // Reset for two cycles, then idle state with no request.
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(fsm_busy), 0);
    check("rst_read_req", 32'(mem.read_req), 0);
    check("rst_mem_wr_req", 32'(mem.mem_wr_req), 0);
    check("rst_tag", 32'(write_tag_array), 0);
    check("rst_wda", 32'(write_data_array), 0);
    check("rst_wrt_mem", 32'(wrt_mem), 0);
    check("rst_mem_addr", 32'(mem.memory_address), 32'h1234);
    check("rst_cache_addr", 32'(cache_address), 32'h1234);

    // Hit store is written through.
    tick();
    wrt = 1'b1;
    wr_q.push_back('{addr: 16'h1234, data: '0, chk: 1'b0, wmem: 1'b1});
    @(negedge clk);
    check("hit_mem_addr", 32'(mem.memory_address), 32'h1234);
    check("hit_busy", 32'(fsm_busy), 0);
    tick();
    wrt = 1'b0;
    tick();

    // Latency 3: busy T..T+11.
    run_miss("fill", 16'h1236, 99, 0, 1'b0, 12);
    // Latency 1: busy T..T+9.
    mem_lat = 1;
    run_miss("fast", 16'h4F02, 99, 0, 1'b0, 10);
    mem_lat = 3;
    // Two pause cycles after the third request push the last return out by 2.
    run_miss("pause", 16'h1236, 3, 2, 1'b0, 14);

    // Reset after the 4th return: 7 reads issued, 4 words written, no tag.
    push_fill(16'h8A1C, 7, 4, 1'b0);
    w0            = wr_total;
    miss_address  = 16'h8A1C;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    for (int k = 0; k < 40 && (wr_total - w0) < 4; k++) tick();
    check("rst_wait_4th", 32'(wr_total - w0), 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(fsm_busy), 0);
    check("rstmid_read_req", 32'(mem.read_req), 0);
    check("rstmid_cache_addr", 32'(cache_address), 32'h8A1C);
    // Remaining returns land in IDLE and must be ignored.
    for (int k = 0; k < 6; k++) tick();
    check_drained("rstmid");
    run_miss("restart", 16'h8A1C, 99, 0, 1'b0, 12);

`ifdef CACHE_FILL_WB_EN
    // Dirty victim: 8 write-backs at 0xAB0..0xABE, then the fill; busy T..T+19.
    run_miss("wb", 16'h1236, 99, 0, 1'b1, 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
